// File: rtl/rs_enc_beat16.sv
// rs_enc_beat16: systematic RS(255,239) encoder over GF(2^8), 15 message beats in, message + 1 parity beat out.
// Latency: data beats forwarded 1 cycle after accept; parity beat 2 cycles after the 15th accept.
// Backpressure: ready drops for the single parity cycle per frame; output side never stalls. Option: RS_ENC_ERR_INJECT_EN.
module rs_enc_beat16 (
    input  logic         clk,
    input  logic         rst_n,
`ifdef RS_ENC_ERR_INJECT_EN
    input  logic         err_inject,
`endif
    input  logic [127:0] data_in,
    input  logic         valid_in,
    output logic         ready,
    output logic [127:0] data_out,
    output logic         valid_out,
    output logic         sop_out,
    output logic         eop_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return r;
    endfunction

    // Expands prod (x + alpha^i), i = 0..15, at elaboration; returns g[15..0] (monic x^16 term dropped).
    function automatic logic [127:0] gen_poly();
        logic [16:0][7:0] c;
        logic [7:0]       root;
        c    = '0;
        c[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int k = 16; k >= 1; k--) begin
                c[5'(k)] = c[5'(k - 1)] ^ gf_mul(c[5'(k)], root);
            end
            c[0] = gf_mul(c[0], root);
            root = gf_mul(root, 8'h02);
        end
        return c[15:0];
    endfunction

    localparam logic [15:0][7:0] GEN = gen_poly();

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic [3:0]       cnt_q;
    logic [15:0][7:0] par_q;
    logic [15:0][7:0] par_step;
    logic [127:0]     beat_sym;
    logic [127:0]     par_out;
    logic [7:0]       fb;

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_DATA: begin
                ready  = 1'b1;
                accept = valid_in;
                if (valid_in && cnt_q == 4'd14) state_d = ST_PARITY;
            end
            ST_PARITY: state_d = ST_DATA;
            default:   state_d = ST_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_DATA;
        else        state_q <= state_d;
    end

    // Lane 0 of the first beat is the x^255 pad and never carries data.
    always_comb begin
        beat_sym = data_in;
        if (cnt_q == 4'd0) beat_sym[7:0] = 8'h00;
        par_step = par_q;
        fb       = 8'h00;
        for (int l = 0; l < 16; l++) begin
            fb = beat_sym[l*8 +: 8] ^ par_step[0];
            for (int j = 0; j < 15; j++) begin
                par_step[4'(j)] = par_step[4'(j + 1)] ^ gf_mul(fb, GEN[4'(15 - j)]);
            end
            par_step[15] = gf_mul(fb, GEN[0]);
        end
    end

`ifdef RS_ENC_ERR_INJECT_EN
    assign par_out = par_q ^ {7'b0, err_inject, 120'b0};
`else
    assign par_out = par_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q     <= '0;
            cnt_q     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            if (accept) begin
                par_q     <= par_step;
                cnt_q     <= cnt_q + 4'd1;
                data_out  <= beat_sym;
                valid_out <= 1'b1;
                sop_out   <= (cnt_q == 4'd0);
            end else if (state_q == ST_PARITY) begin
                data_out  <= par_out;
                valid_out <= 1'b1;
                eop_out   <= 1'b1;
                par_q     <= '0;
                cnt_q     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rs_enc_beat16.sv
// Scoreboard bench for rs_enc_beat16: long-division parity model plus receiver-side syndrome evaluation.
module tb_rs_enc_beat16;

    typedef logic [14:0][127:0] frame_t;
    typedef struct packed {
        logic [127:0] dat;
        logic         sop;
        logic         eop;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] data_in = '0;
    logic         valid_in = 1'b0;
    logic         ready;
    logic [127:0] data_out;
    logic         valid_out;
    logic         sop_out;
    logic         eop_out;
`ifdef RS_ENC_ERR_INJECT_EN
    logic         err_inject = 1'b0;
`endif

    rs_enc_beat16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef RS_ENC_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready     (ready),
        .data_out  (data_out),
        .valid_out (valid_out),
        .sop_out   (sop_out),
        .eop_out   (eop_out)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           bad = 0;
    int           stalls = 0;
    logic         inj = 1'b0;
    logic [7:0]   exp_syn = 8'h00;
    logic [7:0]   gpoly [17];
    exp_t         sb_q [$];
    exp_t         mon_e;
    int           ob = 0;
    logic [7:0]   cw [256];
    logic [127:0] last_par = '0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return r;
    endfunction

    // Remainder of m(x)*x^16 / g(x) by schoolbook long division over the whole codeword.
    function automatic logic [127:0] calc_parity(input frame_t f);
        logic [7:0]   r [256];
        logic [7:0]   c;
        logic [127:0] p;
        for (int d = 0; d < 256; d++) r[d] = 8'h00;
        for (int b = 0; b < 15; b++)
            for (int k = 0; k < 16; k++)
                r[255 - (b*16 + k)] = f[b][k*8 +: 8];
        r[255] = 8'h00;
        for (int d = 255; d >= 16; d--) begin
            c = r[d];
            for (int j = 0; j <= 16; j++) r[d - 16 + j] = r[d - 16 + j] ^ gmul(c, gpoly[j]);
        end
        p = '0;
        for (int k = 0; k < 16; k++) p[k*8 +: 8] = r[15 - k];
        return p;
    endfunction

    task automatic send_frame(input frame_t f, input int nbeats, input int gap_pct);
        exp_t   e;
        frame_t fz;
        logic   acc;
        fz = f;
        fz[0][7:0] = 8'h00;
        for (int b = 0; b < nbeats; b++) begin
            if (gap_pct > 0 && $urandom_range(99) < 32'(gap_pct)) begin
                valid_in = 1'b0;
                repeat ($urandom_range(3, 1)) @(posedge clk);
                #1;
            end
            data_in  = f[b];
            valid_in = 1'b1;
            acc      = 1'b0;
            for (int w = 0; w < 40 && !acc; w++) begin
                @(negedge clk);
                acc = ready;
                if (!acc) stalls++;
                else begin
                    e.dat = fz[b];
                    e.sop = (b == 0);
                    e.eop = 1'b0;
                    sb_q.push_back(e);
                end
                @(posedge clk);
                #1;
            end
            chk("accept", 128'(acc), 128'(1));
        end
        valid_in = 1'b0;
        data_in  = '0;
        if (nbeats == 15) begin
            e.dat = calc_parity(fz);
            if (inj) e.dat[127:120] = e.dat[127:120] ^ 8'h01;
            e.sop = 1'b0;
            e.eop = 1'b1;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        int low;
        low = 0;
        repeat (6) begin
            @(negedge clk);
            if (!ready) low++;
        end
        chk("drain_empty", 128'(sb_q.size()), 128'(0));
        chk("ready_low_cycles", 128'(low), 128'(1));
        @(posedge clk);
        #1;
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        for (int b = 0; b < 15; b++) f[b] = {$urandom, $urandom, $urandom, $urandom};
        return f;
    endfunction

    always @(negedge clk) begin
        logic [7:0] ai;
        logic [7:0] s;
        if (!rst_n) begin
            ob = 0;
        end else begin
            if (ob == 15) chk("parity_no_gap", 128'(valid_out), 128'(1));
            if (valid_out) begin
                chk("sb_has_entry", 128'(sb_q.size() > 0), 128'(1));
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    chk("data_out", data_out, mon_e.dat);
                    chk("sop_out", 128'(sop_out), 128'(mon_e.sop));
                    chk("eop_out", 128'(eop_out), 128'(mon_e.eop));
                end
                if (sop_out) ob = 0;
                if (ob < 16)
                    for (int k = 0; k < 16; k++) cw[ob*16 + k] = data_out[k*8 +: 8];
                ob++;
                if (eop_out) begin
                    chk("frame_len", 128'(ob), 128'(16));
                    ai = 8'h01;
                    for (int i = 0; i < 16; i++) begin
                        s = 8'h00;
                        for (int n = 0; n < 256; n++) s = gmul(s, ai) ^ cw[n];
                        chk($sformatf("syndrome%0d", i), 128'(s), 128'(exp_syn));
                        ai = gmul(ai, 8'h02);
                    end
                    last_par = data_out;
                    ob = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t     f;
        logic [7:0] root;
        for (int k = 0; k < 17; k++) gpoly[k] = 8'h00;
        gpoly[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int k = 16; k >= 1; k--) gpoly[k] = gpoly[k-1] ^ gmul(gpoly[k], root);
            gpoly[0] = gmul(gpoly[0], root);
            root = gmul(root, 8'h02);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_valid_out", 128'(valid_out), 128'(0));
        chk("rst_data_out", data_out, 128'(0));
        chk("rst_sop_out", 128'(sop_out), 128'(0));
        chk("rst_eop_out", 128'(eop_out), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        f = '0;
        send_frame(f, 15, 0);
        drain();
        chk("zero_parity", last_par, 128'(0));

        f = '0;
        f[14][127:120] = 8'h01;
        send_frame(f, 15, 0);
        drain();
        for (int k = 0; k < 16; k++)
            chk($sformatf("gen_lane%0d", k), 128'(last_par[k*8 +: 8]), 128'(gpoly[15 - k]));

        f = '0;
        f[0][7:0] = 8'hFF;
        send_frame(f, 15, 0);
        drain();
        chk("pad_parity", last_par, 128'(0));

        stalls = 0;
        repeat (3) send_frame(rand_frame(), 15, 0);
        drain();
        chk("b2b_stalls", 128'(stalls), 128'(2));

        for (int n = 0; n < 100; n++) send_frame(rand_frame(), 15, 30);
        drain();

        send_frame(rand_frame(), 8, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_valid_out", 128'(valid_out), 128'(0));
            chk("midrst_eop_out", 128'(eop_out), 128'(0));
            chk("midrst_ready", 128'(ready), 128'(1));
        end
        chk("midrst_sb_empty", 128'(sb_q.size()), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        f = '0;
        send_frame(f, 15, 0);
        drain();
        chk("post_rst_parity", last_par, 128'(0));

`ifdef RS_ENC_ERR_INJECT_EN
        inj        = 1'b1;
        exp_syn    = 8'h01;
        err_inject = 1'b1;
        f = '0;
        send_frame(f, 15, 0);
        drain();
        chk("inject_lane15", 128'(last_par[127:120]), 128'(8'h01));
        err_inject = 1'b0;
        inj        = 1'b0;
        exp_syn    = 8'h00;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs_enc_beat16.md
# rs_enc_beat16

Systematic Reed-Solomon RS(255,239) encoder over GF(2^8), t = 8, 16 parity symbols, 16 symbols per 128-bit beat.
- Accepts a 15-beat message frame, forwards it unchanged and appends one 16-byte parity beat, so each frame is 16 beats.
- Transmit-side counterpart of the 16-lane syndrome slices: every frame it emits must produce 16 zero syndromes at the receiver.

## Interface
Parameters:
- NONE (field polynomial 0x11D, alpha = 0x02, generator roots alpha^0..alpha^15 are fixed)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, asynchronous, active-low
- data_in  input  128  message beat; lane k = data_in[k*8 +: 8]
- valid_in  input  1  data_in valid this cycle
- ready  output  1  encoder accepts data_in this cycle
- data_out  output  128  forwarded message beat or parity beat
- valid_out  output  1  data_out valid
- sop_out  output  1  first beat of output frame
- eop_out  output  1  parity beat (last beat of frame)
- err_inject  input  1  only with RS_ENC_ERR_INJECT_EN; see Configuration

## Operation
- Symbol order:
  - beat 0 lane 0 is the highest-degree codeword coefficient (x^255); lanes are ascending within a beat, beats ascending.
  - Parity lane 0 = coefficient of x^15, lane 15 = x^0.
- Pad symbol: beat 0 lane 0 is a pad. The encoder forces it to 0x00 both in the LFSR and on data_out. The message is therefore 239 symbols.
- Parity register: par[0..15], 8 bits each. Per accepted beat, 16 unrolled LFSR steps, lane 0 first:
  - fb = sym ^ par[0]
  - par[j] = par[j+1] ^ mul(fb, g[15-j]) for j = 0..14
  - par[15] = mul(fb, g[0])
  - g(x) = x^16 + g[15]x^15 + ... + g[0] = prod_{j=0..15}(x + alpha^j); coefficients are a constant table.
- Beat counter cnt, 4 bits, counts accepted data beats.
- FSM states:
  - DATA: ready = 1; accept when valid_in. cnt++. On cnt == 14 accepted, go to PARITY.
  - PARITY: ready = 0; emit final par as a beat; clear par and cnt; return to DATA.
- The first accepted beat uses par = 0. Frames are independent.
- Gaps with valid_in = 0 in DATA hold all state. No timeout.

## Timing
- Reset values: par = 0, cnt = 0, state DATA, data_out = 0, valid_out = 0, sop_out = 0, eop_out = 0.
  - ready = 1 (combinational from state).
- Forwarding latency: 1 cycle from accepted input beat to valid_out.
- sop_out = 1 with output beat cnt == 0. eop_out = 1 only on the parity beat.
- The parity beat appears on data_out the cycle after the 15th data beat appears, i.e. 2 cycles after the 15th beat is accepted.
- ready is low for exactly one cycle per frame, the PARITY cycle. Sustained throughput is 15/16.
- valid_in while ready = 0 is ignored; the source must hold the beat.
- Back-to-back frames: the first beat of the next frame is accepted the cycle after PARITY, which outputs directly after the parity beat with no gap.
- Reset mid-frame: all state is discarded immediately. The next accepted beat is beat 0 of a new frame. No partial parity beat is emitted.
- No backpressure on the output side; the downstream consumer always accepts.

## Configuration
- RS_ENC_ERR_INJECT_EN defined:
  - err_inject port exists.
  - When err_inject = 1 in the PARITY cycle, data_out lane 15 of the parity beat is XORed with 0x01. Internal state is unaffected.
  - Used to exercise the decoder's nonzero-syndrome path.
- Undefined: the port is absent and the parity beat is always exact.

## Test plan
- Reset, then 15 beats of all-zero data -> 15 zero beats forwarded, then parity beat = 0, eop_out = 1, ready low exactly 1 cycle.
- Single symbol 0x01 at beat 14 lane 15, all else 0 -> parity lanes 0..15 = g[15]..g[0] (golden table).
- Beat 0 lane 0 = 0xFF, all else 0 -> data_out beat 0 lane 0 = 0x00 and parity beat = 0.
- 100 random frames with random valid_in gaps -> each 16-beat output frame fed to 16 syndrome slices (i = 0..15) gives all syndromes 0x00. Throughput is 15/16 when there are no gaps.
- rst_n asserted after beat 7 accepted, then a full zero frame -> no eop_out before reset recovery; next frame parity = 0, sop_out on its first beat.
- With RS_ENC_ERR_INJECT_EN and err_inject = 1 on a zero frame -> parity beat lane 15 = 0x01; downstream syndromes are S_i = 0x01 for all i (error at x^0).
